issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_issue_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Issue scheduler: dispatches up to four in-order slots per cycle to the
// fxu_0, fxu_1, lsu and branch reservation stations. A unit takes a slot
// only while it has a free credit. Dispatch results are registered.
module issue_scheduler #(
    parameter int RS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  slot_valid_flat,
    input  logic [7:0]  slot_class_flat,
    input  logic [15:0] slot_rob_idx_flat,
    input  logic        fxu_0_release,
    input  logic        fxu_1_release,
    input  logic        lsu_release,
    input  logic        branch_release,
    input  logic        flush,
    output logic [2:0]  num_dispatch,
    output logic        out_fxu_0_valid,
    output logic        out_fxu_1_valid,
    output logic        out_lsu_valid,
    output logic        out_branch_valid,
    output logic [3:0]  out_fxu_0_rob_idx,
    output logic [3:0]  out_fxu_1_rob_idx,
    output logic [3:0]  out_lsu_rob_idx,
    output logic [3:0]  out_branch_rob_idx,
    output logic [15:0] stall_count,
    output logic        overflow_err
);

    typedef enum logic [1:0] {
        CLS_FXU     = 2'd0,
        CLS_LSU     = 2'd1,
        CLS_BRANCH  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } slot_class_e;

    // Unit indices into the per-unit vectors below.
    localparam int U_FXU0 = 0;
    localparam int U_FXU1 = 1;
    localparam int U_LSU  = 2;
    localparam int U_BR   = 3;

    localparam logic [2:0] DEPTH = 3'(RS_DEPTH);

    // Per-unit state and per-cycle decisions.
    logic [2:0]  r_credit   [4];
    logic [3:0]  r_out_valid;
    logic [3:0]  r_out_rob  [4];
    logic [15:0] r_stall_count;
    logic        r_overflow;

    logic [3:0]  w_avail;
    logic [3:0]  w_release;
    logic [3:0]  w_disp;
    logic [3:0]  w_disp_rob [4];
    logic [2:0]  w_num;
    logic        w_blocked;

    // Unpacked slot view; slot 0 is the oldest and lives in the MSBs.
    logic        w_slot_valid [4];
    slot_class_e w_slot_class [4];
    logic [3:0]  w_slot_rob   [4];

    assign w_release = {branch_release, lsu_release, fxu_1_release, fxu_0_release};

    // Split the flat slot buses into per-slot fields.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_slot_valid[k] = slot_valid_flat[3-k];
            w_slot_class[k] = slot_class_e'(slot_class_flat[2*(3-k) +: 2]);
            w_slot_rob[k]   = slot_rob_idx_flat[4*(3-k) +: 4];
        end
    end

    // A unit can accept a slot only while its registered credit is non-zero.
    always_comb begin
        for (int u = 0; u < 4; u++) begin
            w_avail[u] = (r_credit[u] != 3'd0);
        end
    end

    // In-order scan: each slot claims a free unit or blocks every later slot.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_disp    = '0;
        w_num     = '0;
        w_blocked = flush | ~rst_n;
        for (int u = 0; u < 4; u++) begin
            w_disp_rob[u] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            if (!w_blocked) begin
                if (!w_slot_valid[k]) begin
                    w_blocked = 1'b1;
                end else begin
                    case (w_slot_class[k])
                        CLS_FXU: begin
                            if (w_avail[U_FXU0] && !w_disp[U_FXU0]) begin
                                w_disp[U_FXU0]     = 1'b1;
                                w_disp_rob[U_FXU0] = w_slot_rob[k];
                            end else if (w_avail[U_FXU1] && !w_disp[U_FXU1]) begin
                                w_disp[U_FXU1]     = 1'b1;
                                w_disp_rob[U_FXU1] = w_slot_rob[k];
                            end else begin
                                w_blocked = 1'b1;
                            end
                        end
                        CLS_LSU: begin
                            if (w_avail[U_LSU] && !w_disp[U_LSU]) begin
                                w_disp[U_LSU]     = 1'b1;
                                w_disp_rob[U_LSU] = w_slot_rob[k];
                            end else begin
                                w_blocked = 1'b1;
                            end
                        end
                        CLS_BRANCH: begin
                            if (w_avail[U_BR] && !w_disp[U_BR]) begin
                                w_disp[U_BR]     = 1'b1;
                                w_disp_rob[U_BR] = w_slot_rob[k];
                            end else begin
                                w_blocked = 1'b1;
                            end
                        end
                        default: w_blocked = 1'b1;
                    endcase
                    if (!w_blocked) begin
                        w_num = w_num + 3'd1;
                    end
                end
            end
        end
    end

    assign num_dispatch = w_num;

    // Credit bookkeeping: dispatch consumes, release returns, excess release is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            for (int u = 0; u < 4; u++) begin
                r_credit[u] <= DEPTH;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int u = 0; u < 4; u++) begin
                case ({w_disp[u], w_release[u]})
                    2'b10: r_credit[u] <= r_credit[u] - 3'd1;
                    2'b01: begin
                        if (r_credit[u] == DEPTH) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_credit[u] <= r_credit[u] + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered dispatch strobes; the ROB index holds after the strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            // NOTE: the small ROB index registers are reset because their value is visible after reset.
            for (int u = 0; u < 4; u++) begin
                r_out_rob[u] <= '0;
            end
        end else begin
            r_out_valid <= w_disp;
            for (int u = 0; u < 4; u++) begin
                if (w_disp[u]) begin
                    r_out_rob[u] <= w_disp_rob[u];
                end
            end
        end
    end

    // Saturating count of cycles where the oldest slot waited without flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_slot_valid[0] && !flush && (w_num == 3'd0)
                     && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign out_fxu_0_valid    = r_out_valid[U_FXU0];
    assign out_fxu_1_valid    = r_out_valid[U_FXU1];
    assign out_lsu_valid      = r_out_valid[U_LSU];
    assign out_branch_valid   = r_out_valid[U_BR];
    assign out_fxu_0_rob_idx  = r_out_rob[U_FXU0];
    assign out_fxu_1_rob_idx  = r_out_rob[U_FXU1];
    assign out_lsu_rob_idx    = r_out_rob[U_LSU];
    assign out_branch_rob_idx = r_out_rob[U_BR];
    assign stall_count        = r_stall_count;
    assign overflow_err       = r_overflow;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler (RS_DEPTH = 4). Expected dispatch results
// are queued when a step is driven and compared when the registered outputs appear.
module tb_issue_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  slot_valid_flat;
    logic [7:0]  slot_class_flat;
    logic [15:0] slot_rob_idx_flat;
    logic        fxu_0_release;
    logic        fxu_1_release;
    logic        lsu_release;
    logic        branch_release;
    logic        flush;
    logic [2:0]  num_dispatch;
    logic        out_fxu_0_valid;
    logic        out_fxu_1_valid;
    logic        out_lsu_valid;
    logic        out_branch_valid;
    logic [3:0]  out_fxu_0_rob_idx;
    logic [3:0]  out_fxu_1_rob_idx;
    logic [3:0]  out_lsu_rob_idx;
    logic [3:0]  out_branch_rob_idx;
    logic [15:0] stall_count;
    logic        overflow_err;

    // Expected registered outputs: vmask = {fxu0, fxu1, lsu, br}, robs in the same order.
    typedef struct {
        logic [3:0]  vmask;
        logic [15:0] robs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    issue_scheduler #(.RS_DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .slot_valid_flat    (slot_valid_flat),
        .slot_class_flat    (slot_class_flat),
        .slot_rob_idx_flat  (slot_rob_idx_flat),
        .fxu_0_release      (fxu_0_release),
        .fxu_1_release      (fxu_1_release),
        .lsu_release        (lsu_release),
        .branch_release     (branch_release),
        .flush              (flush),
        .num_dispatch       (num_dispatch),
        .out_fxu_0_valid    (out_fxu_0_valid),
        .out_fxu_1_valid    (out_fxu_1_valid),
        .out_lsu_valid      (out_lsu_valid),
        .out_branch_valid   (out_branch_valid),
        .out_fxu_0_rob_idx  (out_fxu_0_rob_idx),
        .out_fxu_1_rob_idx  (out_fxu_1_rob_idx),
        .out_lsu_rob_idx    (out_lsu_rob_idx),
        .out_branch_rob_idx (out_branch_rob_idx),
        .stall_count        (stall_count),
        .overflow_err       (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check num_dispatch, queue expectation,
    // then compare registered outputs just after the posedge.
    task automatic step(input string tag,
                        input logic [3:0]  valid,
                        input logic [7:0]  cls,
                        input logic [15:0] rob,
                        input logic [3:0]  rel,
                        input logic        fl,
                        input logic [2:0]  exp_num,
                        input logic [3:0]  exp_vmask,
                        input logic [15:0] exp_robs,
                        input logic [15:0] exp_stall,
                        input logic        exp_ovf);
        exp_t e;
        exp_t got;
        slot_valid_flat   = valid;
        slot_class_flat   = cls;
        slot_rob_idx_flat = rob;
        fxu_0_release     = rel[3];
        fxu_1_release     = rel[2];
        lsu_release       = rel[1];
        branch_release    = rel[0];
        flush             = fl;
        #1;
        check({tag, ".num"}, 16'(num_dispatch), 16'(exp_num));
        e.vmask = exp_vmask;
        e.robs  = exp_robs;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 16'd0, 16'd1);
        end else begin
            got = exp_q.pop_front();
            check({tag, ".valid"},
                  16'({out_fxu_0_valid, out_fxu_1_valid, out_lsu_valid, out_branch_valid}),
                  16'(got.vmask));
            if (got.vmask[3]) check({tag, ".fxu0_rob"}, 16'(out_fxu_0_rob_idx), 16'(got.robs[15:12]));
            if (got.vmask[2]) check({tag, ".fxu1_rob"}, 16'(out_fxu_1_rob_idx), 16'(got.robs[11:8]));
            if (got.vmask[1]) check({tag, ".lsu_rob"},  16'(out_lsu_rob_idx),   16'(got.robs[7:4]));
            if (got.vmask[0]) check({tag, ".br_rob"},   16'(out_branch_rob_idx), 16'(got.robs[3:0]));
        end
        check({tag, ".stall"}, stall_count, exp_stall);
        check({tag, ".ovf"}, 16'(overflow_err), 16'(exp_ovf));
        @(negedge clk);
    endtask

    initial begin
        rst_n             = 1'b0;
        slot_valid_flat   = 4'b1111;
        slot_class_flat   = 8'b00_00_01_10;
        slot_rob_idx_flat = 16'h1234;
        fxu_0_release     = 1'b0;
        fxu_1_release     = 1'b0;
        lsu_release       = 1'b0;
        branch_release    = 1'b0;
        flush             = 1'b0;

        // Reset: nothing dispatches, all outputs cleared.
        repeat (2) @(negedge clk);
        check("rst.num", 16'(num_dispatch), 16'd0);
        check("rst.valid", 16'({out_fxu_0_valid, out_fxu_1_valid, out_lsu_valid, out_branch_valid}), 16'd0);
        check("rst.robs", {out_fxu_0_rob_idx, out_fxu_1_rob_idx, out_lsu_rob_idx, out_branch_rob_idx}, 16'd0);
        check("rst.stall", stall_count, 16'd0);
        check("rst.ovf", 16'(overflow_err), 16'd0);
        rst_n = 1'b1;

        // Full-width dispatch right after reset.
        step("t1_all4", 4'b1111, 8'b00_00_01_10, 16'h1234, 4'b0000, 1'b0, 3'd4, 4'b1111, 16'h1234, 16'd0, 1'b0);
        // Third FXU blocks the LSU behind it; fxu releases offset the dispatches.
        step("t2_fxu3", 4'b1111, 8'b00_00_00_01, 16'h5678, 4'b1100, 1'b0, 3'd2, 4'b1100, 16'h5600, 16'd0, 1'b0);
        step("t3_idle", 4'b0000, 8'h00, 16'h0000, 4'b0000, 1'b0, 3'd0, 4'b0000, 16'h0000, 16'd0, 1'b0);
        // Invalid slot 1 stops the scan; lsu credit restored to 4, branch unchanged.
        step("t5_hole", 4'b1011, 8'b10_00_00_00, 16'h9000, 4'b0011, 1'b0, 3'd1, 4'b0001, 16'h0009, 16'd0, 1'b0);

        // LSU-only stream with no release: four dispatches then stalls.
        for (int i = 0; i < 8; i++) begin
            if (i < 4)
                step("t6_lsu", 4'b1000, 8'b01_00_00_00, {4'(i + 1), 12'h000}, 4'b0000, 1'b0,
                     3'd1, 4'b0010, {8'h00, 4'(i + 1), 4'h0}, 16'd0, 1'b0);
            else
                step("t6_lsu_stall", 4'b1000, 8'b01_00_00_00, {4'(i + 1), 12'h000}, 4'b0000, 1'b0,
                     3'd0, 4'b0000, 16'h0000, 16'(i - 3), 1'b0);
        end

        // Release with empty credit: no dispatch this cycle, dispatch next.
        step("t7_rel", 4'b1000, 8'b01_00_00_00, 16'h9000, 4'b0010, 1'b0, 3'd0, 4'b0000, 16'h0000, 16'd5, 1'b0);
        step("t7_go", 4'b1000, 8'b01_00_00_00, 16'h9000, 4'b0000, 1'b0, 3'd1, 4'b0010, 16'h0090, 16'd5, 1'b0);
        // Illegal class at slot 0 stalls.
        step("t8_ill", 4'b1111, 8'b11_00_00_00, 16'h1234, 4'b0000, 1'b0, 3'd0, 4'b0000, 16'h0000, 16'd6, 1'b0);
        // Flush blocks dispatch and stall counting; lsu release still applies.
        step("t9_flush", 4'b1111, 8'b00_00_10_00, 16'h1234, 4'b0010, 1'b1, 3'd0, 4'b0000, 16'h0000, 16'd6, 1'b0);
        step("t10_mix", 4'b1111, 8'b01_00_00_10, 16'hABCD, 4'b0000, 1'b0, 3'd4, 4'b1111, 16'hBCAD, 16'd6, 1'b0);

        // fxu_0 credit 2 -> 3 -> 4, then an excess release is flagged.
        step("t11_rel1", 4'b0000, 8'h00, 16'h0000, 4'b1000, 1'b0, 3'd0, 4'b0000, 16'h0000, 16'd6, 1'b0);
        step("t11_rel2", 4'b0000, 8'h00, 16'h0000, 4'b1000, 1'b0, 3'd0, 4'b0000, 16'h0000, 16'd6, 1'b0);
        step("t11_ovf", 4'b0000, 8'h00, 16'h0000, 4'b1000, 1'b0, 3'd0, 4'b0000, 16'h0000, 16'd6, 1'b1);
        // Drain: fxu_0 holds exactly 4 credits, fxu_1 holds 2.
        step("t11_d1", 4'b1111, 8'h00, 16'h1234, 4'b0000, 1'b0, 3'd2, 4'b1100, 16'h1200, 16'd6, 1'b1);
        step("t11_d2", 4'b1111, 8'h00, 16'h1234, 4'b0000, 1'b0, 3'd2, 4'b1100, 16'h1200, 16'd6, 1'b1);
        step("t11_d3", 4'b1111, 8'h00, 16'h1234, 4'b0000, 1'b0, 3'd1, 4'b1000, 16'h1000, 16'd6, 1'b1);
        step("t11_d4", 4'b1111, 8'h00, 16'h1234, 4'b0000, 1'b0, 3'd1, 4'b1000, 16'h1000, 16'd6, 1'b1);
        step("t11_d5", 4'b1111, 8'h00, 16'h1234, 4'b0000, 1'b0, 3'd0, 4'b0000, 16'h0000, 16'd7, 1'b1);

        // Reset mid-dispatch clears the registered strobe immediately.
        slot_valid_flat   = 4'b1000;
        slot_class_flat   = 8'b10_00_00_00;
        slot_rob_idx_flat = 16'h7000;
        #1;
        check("t12.num", 16'(num_dispatch), 16'd1);
        @(posedge clk);
        #1;
        check("t12.br_valid", 16'(out_branch_valid), 16'd1);
        check("t12.br_rob", 16'(out_branch_rob_idx), 16'd7);
        rst_n = 1'b0;
        #1;
        check("t12.rst_valid", 16'({out_fxu_0_valid, out_fxu_1_valid, out_lsu_valid, out_branch_valid}), 16'd0);
        check("t12.rst_rob", 16'(out_branch_rob_idx), 16'd0);
        check("t12.rst_num", 16'(num_dispatch), 16'd0);
        check("t12.rst_stall", stall_count, 16'd0);
        check("t12.rst_ovf", 16'(overflow_err), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("t13_all4", 4'b1111, 8'b00_00_01_10, 16'h4321, 4'b0000, 1'b0, 3'd4, 4'b1111, 16'h4321, 16'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
